// File: rtl/timer_countdown.sv
// Programmable down-counting event timer: prescaled ticks, one-shot or periodic
// reload, one-cycle expiry pulse and a sticky interrupt.
module timer_countdown #(
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cke_i,
  input  logic [DATA_W-1:0]  TIMER_LOAD_VALUE,
  input  logic               TIMER_LOAD,
  input  logic               TIMER_START,
  input  logic               TIMER_STOP,
  input  logic               TIMER_PERIODIC,
  input  logic [PRESC_W-1:0] TIMER_PRESCALE,
  input  logic               TIMER_IRQ_EN,
  input  logic               TIMER_IRQ_CLR,
  output logic [DATA_W-1:0]  TIMER_CURRENT,
  output logic               TIMER_RUNNING,
  output logic               TIMER_EXPIRED,
  output logic               TIMER_IRQ
);

  typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   count, count_n;
  logic [DATA_W-1:0]   reload, reload_n;
  logic [PRESC_W-1:0]  presc, presc_n;
  logic                expired, expired_n;
  logic                irq, irq_n;
  logic                tick;

  // Equality compare: a prescaler left above a newly lowered PRESCALE
  // simply counts up through the wrap before it next matches.
  assign tick = (presc == TIMER_PRESCALE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      presc   <= '0;
      expired <= 1'b0;
      irq     <= 1'b0;
    end else if (cke_i) begin
      state   <= state_n;
      count   <= count_n;
      reload  <= reload_n;
      presc   <= presc_n;
      expired <= expired_n;
      irq     <= irq_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    presc_n   = presc;
    expired_n = 1'b0;
    if (TIMER_LOAD) begin
      count_n  = TIMER_LOAD_VALUE;
      reload_n = TIMER_LOAD_VALUE;
      presc_n  = '0;
    end else if (TIMER_STOP) begin
      state_n = IDLE;
      presc_n = '0;
    end else if (TIMER_START && state == IDLE) begin
      if (count != '0) begin
        state_n = RUNNING;
        presc_n = '0;
      end
    end else if (state == RUNNING) begin
      if (count == '0) begin
        // Only reachable after loading zero while running.
        state_n = IDLE;
        presc_n = '0;
      end else if (tick) begin
        presc_n = '0;
        if (count > DATA_W'(1)) begin
          count_n = count - DATA_W'(1);
        end else begin
          expired_n = 1'b1;
          if (TIMER_PERIODIC) begin
            count_n = reload;
          end else begin
            count_n = '0;
            state_n = IDLE;
          end
        end
      end else begin
        presc_n = presc + PRESC_W'(1);
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    irq_n = irq;
    if (TIMER_IRQ_CLR)              irq_n = 1'b0;
    if (expired_n && TIMER_IRQ_EN)  irq_n = 1'b1;
  end

  assign TIMER_CURRENT = count;
  assign TIMER_RUNNING = (state == RUNNING);
  assign TIMER_EXPIRED = expired;
  assign TIMER_IRQ     = irq;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown: vector table for single-step behaviour,
// hand sequences for periodic timing, stop/restart, clock-enable and reset.
module tb_timer_countdown;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cke_i = 1'b1;
  logic [31:0] TIMER_LOAD_VALUE = '0;
  logic        TIMER_LOAD = 1'b0;
  logic        TIMER_START = 1'b0;
  logic        TIMER_STOP = 1'b0;
  logic        TIMER_PERIODIC = 1'b0;
  logic [15:0] TIMER_PRESCALE = '0;
  logic        TIMER_IRQ_EN = 1'b0;
  logic        TIMER_IRQ_CLR = 1'b0;
  logic [31:0] TIMER_CURRENT;
  logic        TIMER_RUNNING;
  logic        TIMER_EXPIRED;
  logic        TIMER_IRQ;

  int n_checks = 0;
  int n_errors = 0;

  timer_countdown #(.DATA_W(32), .PRESC_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i),
    .TIMER_LOAD_VALUE(TIMER_LOAD_VALUE), .TIMER_LOAD(TIMER_LOAD),
    .TIMER_START(TIMER_START), .TIMER_STOP(TIMER_STOP),
    .TIMER_PERIODIC(TIMER_PERIODIC), .TIMER_PRESCALE(TIMER_PRESCALE),
    .TIMER_IRQ_EN(TIMER_IRQ_EN), .TIMER_IRQ_CLR(TIMER_IRQ_CLR),
    .TIMER_CURRENT(TIMER_CURRENT), .TIMER_RUNNING(TIMER_RUNNING),
    .TIMER_EXPIRED(TIMER_EXPIRED), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, load, start, stop, irq_en, irq_clr;
    logic [31:0] lv;
    logic [31:0] cur;
    logic        run, expd, irq;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(logic rst, logic load, logic [31:0] lv, logic start,
                              logic stop, logic irq_en, logic irq_clr,
                              logic [31:0] cur, logic run, logic expd, logic irq);
    vec_t v;
    v.rst = rst; v.load = load; v.lv = lv; v.start = start; v.stop = stop;
    v.irq_en = irq_en; v.irq_clr = irq_clr;
    v.cur = cur; v.run = run; v.expd = expd; v.irq = irq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_pulses();
    TIMER_LOAD = 1'b0; TIMER_START = 1'b0; TIMER_STOP = 1'b0; TIMER_IRQ_CLR = 1'b0;
  endtask

  // Steps until TIMER_EXPIRED is seen; returns edges taken, 0 on timeout.
  task automatic wait_exp(input int bound, output int got);
    got = 0;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (TIMER_EXPIRED === 1'b1) begin
        got = i;
        break;
      end
    end
  endtask

  initial begin
    int got;
    logic [31:0] held;

    //            rst ld lv  st sp ien clr  cur run exp irq
    tbl[0]  = mk(1, 0, 0,  0, 0, 1, 0,   0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 5,  0, 0, 1, 0,   5, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  1, 0, 1, 0,   5, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0,  0, 0, 1, 0,   4, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0,  0, 0, 1, 0,   3, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0,  0, 0, 1, 0,   2, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0,  0, 0, 1, 0,   1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0,  0, 0, 1, 0,   0, 0, 1, 1);
    tbl[8]  = mk(0, 0, 0,  0, 0, 1, 0,   0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0,  1, 0, 1, 0,   0, 0, 0, 1);  // start at zero ignored
    tbl[10] = mk(0, 0, 0,  0, 0, 1, 1,   0, 0, 0, 0);
    tbl[11] = mk(0, 1, 2,  0, 0, 1, 0,   2, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,  1, 0, 1, 0,   2, 1, 0, 0);
    tbl[13] = mk(0, 0, 0,  0, 0, 1, 0,   1, 1, 0, 0);
    tbl[14] = mk(0, 1, 20, 0, 0, 1, 0,  20, 1, 0, 0);  // load suppresses expiry
    tbl[15] = mk(0, 0, 0,  0, 0, 1, 0,  19, 1, 0, 0);
    tbl[16] = mk(0, 1, 0,  0, 0, 1, 0,   0, 1, 0, 0);
    tbl[17] = mk(0, 0, 0,  0, 0, 1, 0,   0, 0, 0, 0);
    tbl[18] = mk(0, 1, 1,  0, 0, 1, 0,   1, 0, 0, 0);
    tbl[19] = mk(0, 0, 0,  1, 0, 1, 0,   1, 1, 0, 0);
    tbl[20] = mk(0, 0, 0,  0, 0, 1, 1,   0, 0, 1, 1);  // set beats clear
    tbl[21] = mk(0, 0, 0,  0, 0, 1, 1,   0, 0, 0, 0);
    tbl[22] = mk(0, 1, 1,  0, 0, 0, 0,   1, 0, 0, 0);
    tbl[23] = mk(0, 0, 0,  1, 0, 0, 0,   1, 1, 0, 0);
    tbl[24] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0);  // irq disabled
    tbl[25] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);
    tbl[26] = mk(0, 1, 3,  0, 0, 0, 0,   3, 0, 0, 0);
    tbl[27] = mk(0, 0, 0,  1, 0, 0, 0,   3, 1, 0, 0);
    tbl[28] = mk(0, 0, 0,  1, 1, 0, 0,   2, 0, 0, 0);  // stop wins, count held
    tbl[29] = mk(0, 0, 0,  0, 0, 0, 0,   2, 0, 0, 0);

    // tbl[28]: count was 3 after start edge, one running edge (tbl[27]->28 is
    // the first edge after start), but stop has priority, so count stays 3.
    tbl[28].cur = 3;
    tbl[29].cur = 3;

    for (int i = 0; i < 30; i++) begin
      rst_i = tbl[i].rst; TIMER_LOAD = tbl[i].load; TIMER_LOAD_VALUE = tbl[i].lv;
      TIMER_START = tbl[i].start; TIMER_STOP = tbl[i].stop;
      TIMER_IRQ_EN = tbl[i].irq_en; TIMER_IRQ_CLR = tbl[i].irq_clr;
      step();
      chk($sformatf("v%0d_cur", i), TIMER_CURRENT, tbl[i].cur);
      chk($sformatf("v%0d_run", i), 32'(TIMER_RUNNING), 32'(tbl[i].run));
      chk($sformatf("v%0d_exp", i), 32'(TIMER_EXPIRED), 32'(tbl[i].expd));
      chk($sformatf("v%0d_irq", i), 32'(TIMER_IRQ), 32'(tbl[i].irq));
    end
    clr_pulses();

    // Periodic, reload 3, prescale 2: pulse every 9 edges after start.
    TIMER_PERIODIC = 1'b1; TIMER_PRESCALE = 16'd2; TIMER_IRQ_EN = 1'b1;
    TIMER_LOAD_VALUE = 32'd3; TIMER_LOAD = 1'b1; step(); clr_pulses();
    TIMER_START = 1'b1; step(); clr_pulses();
    for (int i = 1; i <= 36; i++) begin
      step();
      chk($sformatf("per_exp%0d", i), 32'(TIMER_EXPIRED), 32'((i % 9) == 0));
      chk($sformatf("per_run%0d", i), 32'(TIMER_RUNNING), 32'd1);
      if ((i % 9) == 0) chk($sformatf("per_cur%0d", i), TIMER_CURRENT, 32'd3);
    end
    TIMER_STOP = 1'b1; step(); clr_pulses();
    TIMER_PERIODIC = 1'b0; TIMER_PRESCALE = '0;
    chk("per_stop_run", 32'(TIMER_RUNNING), 32'd0);

    // Stop at 7 of 10, idle 20 cycles, restart: 7 more ticks to expiry.
    TIMER_LOAD_VALUE = 32'd10; TIMER_LOAD = 1'b1; step(); clr_pulses();
    TIMER_START = 1'b1; step(); clr_pulses();
    chk("stp_cur10", TIMER_CURRENT, 32'd10);
    repeat (3) step();
    TIMER_STOP = 1'b1; step(); clr_pulses();
    chk("stp_cur7", TIMER_CURRENT, 32'd7);
    chk("stp_run0", 32'(TIMER_RUNNING), 32'd0);
    repeat (20) step();
    chk("stp_hold", TIMER_CURRENT, 32'd7);
    TIMER_START = 1'b1; step(); clr_pulses();
    chk("stp_restart_run", 32'(TIMER_RUNNING), 32'd1);
    wait_exp(30, got);
    chk("stp_exp_edges", got, 32'd7);
    chk("stp_exp_cur", TIMER_CURRENT, 32'd0);
    step();

    // Clock-enable freeze of 10 cycles delays expiry by exactly 10.
    TIMER_PRESCALE = 16'd1;
    TIMER_LOAD_VALUE = 32'd5; TIMER_LOAD = 1'b1; step(); clr_pulses();
    TIMER_START = 1'b1; step(); clr_pulses();
    repeat (3) step();
    held = TIMER_CURRENT;
    chk("cke_pre", held, 32'd4);
    cke_i = 1'b0;
    repeat (10) step();
    chk("cke_frozen", TIMER_CURRENT, held);
    cke_i = 1'b1;
    wait_exp(30, got);
    chk("cke_exp_edges", got, 32'd7);
    step();
    TIMER_PRESCALE = '0;

    // Reset while cke_i=0 at count 4, with IRQ pending from earlier expiries.
    TIMER_LOAD_VALUE = 32'd6; TIMER_LOAD = 1'b1; step(); clr_pulses();
    TIMER_START = 1'b1; step(); clr_pulses();
    step(); step();
    chk("rst_pre_cur", TIMER_CURRENT, 32'd4);
    chk("rst_pre_irq", 32'(TIMER_IRQ), 32'd1);
    rst_i = 1'b1; cke_i = 1'b0; step();
    chk("rst_cur", TIMER_CURRENT, 32'd0);
    chk("rst_run", 32'(TIMER_RUNNING), 32'd0);
    chk("rst_exp", 32'(TIMER_EXPIRED), 32'd0);
    chk("rst_irq", 32'(TIMER_IRQ), 32'd0);
    rst_i = 1'b0; cke_i = 1'b1; step();
    chk("rst_post_exp", 32'(TIMER_EXPIRED), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- Programmable down-counting event timer with prescaler, one-shot or periodic mode, and an expiry pulse plus a sticky interrupt.
- Complements the free-running timestamp counter: that block measures elapsed time; this block generates events after a programmed time.
- Sits behind the timer software-register block; all control inputs are single-cycle pulses or levels driven from software registers.

Parameters:
- DATA_W, 32, width of the count, reload and current-value paths.
- PRESC_W, 16, width of the prescaler divide value.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cke_i  in  1  clock enable; when 0 every register holds
- TIMER_LOAD_VALUE  in  DATA_W  count/reload value, sampled on TIMER_LOAD
- TIMER_LOAD  in  1  pulse: load count and reload registers
- TIMER_START  in  1  pulse: begin counting
- TIMER_STOP  in  1  pulse: halt counting, keep current count
- TIMER_PERIODIC  in  1  level: 1 = auto-reload on expiry, 0 = one-shot
- TIMER_PRESCALE  in  PRESC_W  level: one tick every PRESCALE+1 enabled cycles
- TIMER_IRQ_EN  in  1  level: enables setting of TIMER_IRQ
- TIMER_IRQ_CLR  in  1  pulse: clears TIMER_IRQ
- TIMER_CURRENT  out  DATA_W  registered current count
- TIMER_RUNNING  out  1  1 while in RUNNING state
- TIMER_EXPIRED  out  1  registered one-cycle expiry pulse
- TIMER_IRQ  out  1  sticky interrupt

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at a clk_i edge, regardless of cke_i):
  - count, reload and prescaler counter go to 0.
  - State goes to IDLE.
  - TIMER_CURRENT=0, TIMER_RUNNING=0, TIMER_EXPIRED=0, TIMER_IRQ=0.
  - Reset mid-count aborts with no expiry pulse.
- cke_i=0: all registers, including TIMER_EXPIRED, hold their values.
- States:
  - IDLE: not counting.
  - RUNNING: counting. TIMER_RUNNING = (state==RUNNING).
- Priority per edge: rst_i > TIMER_LOAD > TIMER_STOP > TIMER_START > counting.
- TIMER_LOAD:
  - count <= LOAD_VALUE, reload <= LOAD_VALUE, prescaler <= 0.
  - State is unchanged.
  - Suppresses any expiry in that same cycle.
- TIMER_STOP: state <= IDLE, prescaler <= 0, count held. It wins over a simultaneous START.
- TIMER_START:
  - In IDLE with count != 0: state <= RUNNING, prescaler <= 0.
  - With count == 0: ignored.
  - In RUNNING: no effect.
- Tick, in RUNNING only:
  - tick = (prescaler == TIMER_PRESCALE); on a tick, prescaler <= 0, otherwise prescaler + 1.
  - A PRESCALE change mid-count takes effect immediately. If prescaler > PRESCALE, it counts up and wraps to 0 modulo 2^PRESC_W before ticking.
- Counting on a tick:
  - count > 1: count - 1.
  - count == 1: expiry.
- Expiry:
  - TIMER_EXPIRED = 1 for exactly the next cycle.
  - If TIMER_IRQ_EN=1, TIMER_IRQ <= 1.
  - Periodic: count <= reload, stay RUNNING.
  - One-shot: count <= 0, state <= IDLE.
- RUNNING with count == 0 (from a LOAD of 0 while running): state <= IDLE, no expiry.
- Latency (PRESCALE=0, count=N):
  - START sampled at edge t; decrements at edges t+1..t+N.
  - TIMER_EXPIRED high during the cycle after edge t+N.
  - Periodic expiry every N cycles; with prescale P, every N*(P+1) cycles.
- TIMER_IRQ:
  - Cleared by TIMER_IRQ_CLR.
  - Set and clear in the same cycle: set wins.
  - IRQ_EN=0 blocks only setting; it does not clear.
- TIMER_CURRENT is the count register itself: zero extra latency, no wrap below 0.

Test Plan:
- Reset, then LOAD_VALUE=5, LOAD, START, PRESCALE=0, one-shot -> CURRENT 5,4,3,2,1,0 on consecutive cycles; EXPIRED high exactly one cycle, in the cycle after the START edge+5; RUNNING falls with it; IRQ=1 with IRQ_EN=1.
- Periodic, LOAD_VALUE=3, PRESCALE=2 -> EXPIRED every 9 cycles for 4 periods; CURRENT reloads to 3; RUNNING stays 1.
- STOP at CURRENT=7 of 10, wait 20 cycles, START -> CURRENT holds 7 while stopped; expiry exactly 7 ticks after the restart edge.
- LOAD(20) in the same cycle count would expire (count=1, tick) -> no EXPIRED pulse; CURRENT=20; still RUNNING; LOAD(0) while running -> next cycle IDLE, no EXPIRED.
- Expiry coincident with IRQ_CLR -> IRQ stays 1. A later IRQ_CLR alone -> IRQ=0. Expiry with IRQ_EN=0 -> EXPIRED pulses, IRQ stays 0.
- rst_i mid-count at CURRENT=4 with cke_i=0 -> all outputs 0 next edge. Also, cke_i=0 for 10 cycles mid-count -> CURRENT and prescaler frozen, expiry delayed by exactly 10 cycles.
